pc_unpacker: RTL and testbench

Downstream counterpart of the upstream PC packer. It takes the single 42-bit word stream arriving from the PC, formatted as {route[9:0], code[7:0], payload[23:0]}. Each word is steered to one of three destinations:
- BD deserializer path
- FPGA-internal config/command path
- Global (BD-to-BD, routed) path

NOP words are discarded; unknown codes are discarded and counted. Each destination has a one-entry registered output buffer, so a stalled destination blocks only while its buffer is full.

---
 rtl/pc_word_pkg.sv | 51 +++++
 rtl/pc_out_slot.sv | 39 +++
 rtl/pc_unpacker.sv | 126 ++++++++++++
 tb/tb_pc_unpacker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_word_pkg.sv
// Shared definitions for the PC word format {route, code, payload}.
// The same constants are used by the upstream packer, so both ends of
// the link agree on field widths and code ranges.
// Contents:
//   field widths NPCcode / NPCdata / NPCroute and full word width NPCword
//   GO_HOME_rt   route value meaning "local to this FPGA"
//   code ranges  BD_CODE_HI, FPGA_CODE_LO/HI, NOP_CODE
//   ERR_W        width of the unknown-code counter
//   dest_t       destination of a word, and classify() which computes it
package pc_word_pkg;

  localparam int NPCcode  = 8;
  localparam int NPCdata  = 24;
  localparam int NPCroute = 10;
  localparam int NPCword  = NPCroute + NPCcode + NPCdata;

  localparam logic [NPCroute-1:0] GO_HOME_rt   = 10'h200;
  localparam logic [NPCcode-1:0]  BD_CODE_HI   = 8'd12;
  localparam logic [NPCcode-1:0]  FPGA_CODE_LO = 8'd13;
  localparam logic [NPCcode-1:0]  FPGA_CODE_HI = 8'd127;
  localparam logic [NPCcode-1:0]  NOP_CODE     = 8'd255;

  localparam int ERR_W = 16;

  typedef enum logic [2:0] {
    DEST_BD,
    DEST_FPGA,
    DEST_GLOBAL,
    DEST_DROP,
    DEST_ERR
  } dest_t;

  // Any non-home route is forwarded as-is, even a NOP code; the code
  // only matters for words that stay on this FPGA.
  function automatic dest_t classify(input logic [NPCroute-1:0] route,
                                     input logic [NPCcode-1:0]  code);
    dest_t d;
    if (route != GO_HOME_rt)
      d = DEST_GLOBAL;
    else if (code <= BD_CODE_HI)
      d = DEST_BD;
    else if ((code >= FPGA_CODE_LO) && (code <= FPGA_CODE_HI))
      d = DEST_FPGA;
    else if (code == NOP_CODE)
      d = DEST_DROP;
    else
      d = DEST_ERR;
    return d;
  endfunction

endpackage

// File: rtl/pc_out_slot.sv
// One-entry registered output buffer with a valid/ack handshake.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   load         capture data_in this edge (only asserted while free)
//   data_in      word to capture
//   a            downstream ack
//   v            buffer holds a word (output valid)
//   data         buffered word
//   free         buffer can accept a word this cycle
module pc_out_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         a,
  output logic         v,
  output logic [W-1:0] data,
  output logic         free
);

  // Free when empty, or when the current word leaves on this same edge,
  // so a steady stream can pass at one word per cycle.
  assign free = !v || a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v    <= 1'b0;
      data <= '0;
    end else if (load) begin
      v    <= 1'b1;
      data <= data_in;
    end else if (a) begin
      v    <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_unpacker.sv
// Steers the 42-bit PC word stream {route, code, payload} to the BD,
// FPGA-internal and Global (routed) destinations. NOP words are dropped,
// unknown codes are dropped and counted.
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   pc_in_d/v/a                incoming word channel (slave)
//   bd_out_code/payload/v/a    BD deserializer channel (master)
//   fpga_out_code/payload/v/a  FPGA config/command channel (master)
//   global_out_route/code/payload/v/a  routed channel (master)
//   err_count                  saturating count of unknown-code words
//   err_last_code              code of the most recent unknown-code word
module pc_unpacker
  import pc_word_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NPCword-1:0]  pc_in_d,
  input  logic                pc_in_v,
  output logic                pc_in_a,
  output logic [NPCcode-1:0]  bd_out_code,
  output logic [NPCdata-1:0]  bd_out_payload,
  output logic                bd_out_v,
  input  logic                bd_out_a,
  output logic [NPCcode-1:0]  fpga_out_code,
  output logic [NPCdata-1:0]  fpga_out_payload,
  output logic                fpga_out_v,
  input  logic                fpga_out_a,
  output logic [NPCroute-1:0] global_out_route,
  output logic [NPCcode-1:0]  global_out_code,
  output logic [NPCdata-1:0]  global_out_payload,
  output logic                global_out_v,
  input  logic                global_out_a,
  output logic [ERR_W-1:0]    err_count,
  output logic [NPCcode-1:0]  err_last_code
);

  localparam int LOCAL_W = NPCcode + NPCdata;

  logic [NPCroute-1:0] route;
  logic [NPCcode-1:0]  code;
  dest_t               dest;
  logic                accept;
  logic                bd_free, fpga_free, global_free;
  logic                bd_load, fpga_load, global_load;
  logic [LOCAL_W-1:0]  bd_data, fpga_data;
  logic [NPCword-1:0]  global_data;

  assign route = pc_in_d[NPCword-1 -: NPCroute];
  assign code  = pc_in_d[LOCAL_W-1 -: NPCcode];
  assign dest  = classify(route, code);

  // Head-of-line acceptance: the word at the input is taken only when its
  // own destination can take it. Dropped words never block. No ack is
  // offered while reset is held.
  always_comb begin
    pc_in_a = 1'b0;
    if (reset) begin
      case (dest)
        DEST_BD:     pc_in_a = bd_free;
        DEST_FPGA:   pc_in_a = fpga_free;
        DEST_GLOBAL: pc_in_a = global_free;
        default:     pc_in_a = 1'b1;
      endcase
    end
  end

  assign accept      = pc_in_v && pc_in_a;
  assign bd_load     = accept && (dest == DEST_BD);
  assign fpga_load   = accept && (dest == DEST_FPGA);
  assign global_load = accept && (dest == DEST_GLOBAL);

  pc_out_slot #(.W(LOCAL_W)) u_bd_slot (
    .clk     (clk),
    .reset   (reset),
    .load    (bd_load),
    .data_in (pc_in_d[LOCAL_W-1:0]),
    .a       (bd_out_a),
    .v       (bd_out_v),
    .data    (bd_data),
    .free    (bd_free)
  );

  pc_out_slot #(.W(LOCAL_W)) u_fpga_slot (
    .clk     (clk),
    .reset   (reset),
    .load    (fpga_load),
    .data_in (pc_in_d[LOCAL_W-1:0]),
    .a       (fpga_out_a),
    .v       (fpga_out_v),
    .data    (fpga_data),
    .free    (fpga_free)
  );

  pc_out_slot #(.W(NPCword)) u_global_slot (
    .clk     (clk),
    .reset   (reset),
    .load    (global_load),
    .data_in (pc_in_d),
    .a       (global_out_a),
    .v       (global_out_v),
    .data    (global_data),
    .free    (global_free)
  );

  assign bd_out_code        = bd_data[LOCAL_W-1 -: NPCcode];
  assign bd_out_payload     = bd_data[NPCdata-1:0];
  assign fpga_out_code      = fpga_data[LOCAL_W-1 -: NPCcode];
  assign fpga_out_payload   = fpga_data[NPCdata-1:0];
  assign global_out_route   = global_data[NPCword-1 -: NPCroute];
  assign global_out_code    = global_data[LOCAL_W-1 -: NPCcode];
  assign global_out_payload = global_data[NPCdata-1:0];

  // Unknown-code bookkeeping; the counter sticks at all-ones rather than
  // wrapping so a flood of bad words is never mistaken for a few.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count     <= '0;
      err_last_code <= '0;
    end else if (accept && (dest == DEST_ERR)) begin
      if (err_count != '1)
        err_count <= err_count + 1'b1;
      err_last_code <= code;
    end
  end

endmodule

// File: tb/tb_pc_unpacker.sv
// Self-checking bench for pc_unpacker: directed scenarios followed by
// randomized traffic, all compared against a per-destination model.
module tb_pc_unpacker;

  logic        clk;
  logic        reset;
  logic [41:0] pc_in_d;
  logic        pc_in_v;
  logic        pc_in_a;
  logic [7:0]  bd_out_code;
  logic [23:0] bd_out_payload;
  logic        bd_out_v;
  logic        bd_out_a;
  logic [7:0]  fpga_out_code;
  logic [23:0] fpga_out_payload;
  logic        fpga_out_v;
  logic        fpga_out_a;
  logic [9:0]  global_out_route;
  logic [7:0]  global_out_code;
  logic [23:0] global_out_payload;
  logic        global_out_v;
  logic        global_out_a;
  logic [15:0] err_count;
  logic [7:0]  err_last_code;

  int checks = 0;
  int errors = 0;

  // Model state: one held word per destination (0 BD, 1 FPGA, 2 Global)
  bit          m_full [3];
  logic [41:0] m_word [3];
  int          m_err;
  logic [7:0]  m_last;
  bit          last_accept;

  pc_unpacker dut (
    .clk                (clk),
    .reset              (reset),
    .pc_in_d            (pc_in_d),
    .pc_in_v            (pc_in_v),
    .pc_in_a            (pc_in_a),
    .bd_out_code        (bd_out_code),
    .bd_out_payload     (bd_out_payload),
    .bd_out_v           (bd_out_v),
    .bd_out_a           (bd_out_a),
    .fpga_out_code      (fpga_out_code),
    .fpga_out_payload   (fpga_out_payload),
    .fpga_out_v         (fpga_out_v),
    .fpga_out_a         (fpga_out_a),
    .global_out_route   (global_out_route),
    .global_out_code    (global_out_code),
    .global_out_payload (global_out_payload),
    .global_out_v       (global_out_v),
    .global_out_a       (global_out_a),
    .err_count          (err_count),
    .err_last_code      (err_last_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Destination rules: 0 BD, 1 FPGA, 2 Global, 3 drop, 4 unknown code
  function automatic int modelDest(input logic [41:0] w);
    int c;
    c = int'(w[31:24]);
    if (w[41:32] != 10'h200) return 2;
    if (c <= 12) return 0;
    if (c >= 13 && c <= 127) return 1;
    if (c == 255) return 3;
    return 4;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_word[i] = '0;
    end
    m_err  = 0;
    m_last = 8'd0;
  endfunction

  // One clock cycle: drive at the falling edge, compare outputs and the
  // input ack against the model, then advance the model at the rising edge.
  task automatic applyStimulus(input bit v, input logic [41:0] d,
                               input bit ba, input bit fa, input bit ga);
    int dst;
    bit down [3];
    bit exp_a;
    @(negedge clk);
    pc_in_v      = v;
    pc_in_d      = d;
    bd_out_a     = ba;
    fpga_out_a   = fa;
    global_out_a = ga;
    down[0] = ba; down[1] = fa; down[2] = ga;
    #1;
    dst   = modelDest(d);
    exp_a = (reset == 1'b1) && ((dst >= 3) || !m_full[dst] || down[dst]);
    if (v) checkOutput("pc_in_a", {31'd0, pc_in_a}, {31'd0, exp_a});
    checkOutput("bd_v", {31'd0, bd_out_v}, {31'd0, m_full[0]});
    if (m_full[0]) begin
      checkOutput("bd_code", {24'd0, bd_out_code}, {24'd0, m_word[0][31:24]});
      checkOutput("bd_payload", {8'd0, bd_out_payload}, {8'd0, m_word[0][23:0]});
    end
    checkOutput("fpga_v", {31'd0, fpga_out_v}, {31'd0, m_full[1]});
    if (m_full[1]) begin
      checkOutput("fpga_code", {24'd0, fpga_out_code}, {24'd0, m_word[1][31:24]});
      checkOutput("fpga_payload", {8'd0, fpga_out_payload}, {8'd0, m_word[1][23:0]});
    end
    checkOutput("glob_v", {31'd0, global_out_v}, {31'd0, m_full[2]});
    if (m_full[2]) begin
      checkOutput("glob_route", {22'd0, global_out_route}, {22'd0, m_word[2][41:32]});
      checkOutput("glob_code", {24'd0, global_out_code}, {24'd0, m_word[2][31:24]});
      checkOutput("glob_payload", {8'd0, global_out_payload}, {8'd0, m_word[2][23:0]});
    end
    checkOutput("err_count", {16'd0, err_count}, m_err);
    checkOutput("err_last", {24'd0, err_last_code}, {24'd0, m_last});
    last_accept = v && exp_a;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        if (last_accept && dst == i) begin
          m_full[i] = 1'b1;
          m_word[i] = d;
        end else if (m_full[i] && down[i]) begin
          m_full[i] = 1'b0;
        end
      end
      if (last_accept && dst == 4) begin
        if (m_err < 65535) m_err++;
        m_last = d[31:24];
      end
    end
  endtask

  function automatic logic [41:0] randWord();
    logic [9:0]  rt;
    logic [7:0]  cd;
    logic [23:0] pl;
    int sel;
    rt = 10'h200;
    if ($urandom_range(0, 7) == 0) begin
      rt = 10'($urandom_range(0, 1023));
      if (rt == 10'h200) rt = 10'h001;
    end
    sel = $urandom_range(0, 9);
    if (sel <= 3)      cd = 8'($urandom_range(0, 12));
    else if (sel <= 6) cd = 8'($urandom_range(13, 127));
    else if (sel == 7) cd = 8'd255;
    else               cd = 8'($urandom_range(128, 254));
    pl = 24'($urandom);
    return {rt, cd, pl};
  endfunction

  initial begin
    bit          pend;
    logic [41:0] w;
    bit          v;
    int          n;

    reset = 1'b0;
    pc_in_v = 1'b0; pc_in_d = '0;
    bd_out_a = 1'b1; fpga_out_a = 1'b1; global_out_a = 1'b1;
    modelClear();

    // Reset held: no acks even with a word offered, everything cleared
    repeat (3) applyStimulus(1'b1, {10'h200, 8'd5, 24'h000005}, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_bd_data", {bd_out_code, bd_out_payload}, 32'd0);
    checkOutput("rst_fpga_data", {fpga_out_code, fpga_out_payload}, 32'd0);
    checkOutput("rst_glob_data", {global_out_code, global_out_payload}, 32'd0);
    checkOutput("rst_glob_route", {22'd0, global_out_route}, 32'd0);
    #2 reset = 1'b1;
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Back-to-back words to each destination
    applyStimulus(1'b1, {10'h200, 8'd5, 24'hABCDEF}, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("t2_bd_v", {31'd0, bd_out_v}, 32'd1);
    checkOutput("t2_bd", {bd_out_code, bd_out_payload}, 32'h05ABCDEF);
    applyStimulus(1'b1, {10'h200, 8'd20, 24'h000001}, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("t2_fpga", {fpga_out_code, fpga_out_payload}, 32'h14000001);
    applyStimulus(1'b1, {10'h005, 8'd5, 24'h123456}, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("t2_glob_v", {31'd0, global_out_v}, 32'd1);
    checkOutput("t2_glob", {global_out_code, global_out_payload}, 32'h05123456);
    checkOutput("t2_glob_route", {22'd0, global_out_route}, 32'h005);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // BD stalled: second BD word blocks the FPGA word behind it
    applyStimulus(1'b1, {10'h200, 8'd3, 24'h111111}, 1'b0, 1'b1, 1'b1);
    #1 checkOutput("t3_bd_first", {bd_out_code, bd_out_payload}, 32'h03111111);
    repeat (2) applyStimulus(1'b1, {10'h200, 8'd4, 24'h222222}, 1'b0, 1'b1, 1'b1);
    #1 checkOutput("t3_bd_held", {bd_out_code, bd_out_payload}, 32'h03111111);
    applyStimulus(1'b1, {10'h200, 8'd4, 24'h222222}, 1'b1, 1'b1, 1'b1);
    #1 checkOutput("t3_bd_second", {bd_out_code, bd_out_payload}, 32'h04222222);
    applyStimulus(1'b1, {10'h200, 8'd50, 24'h333333}, 1'b1, 1'b1, 1'b1);
    #1 checkOutput("t3_fpga", {fpga_out_code, fpga_out_payload}, 32'h32333333);

    // Unknown code counted, NOP silently dropped
    applyStimulus(1'b1, {10'h200, 8'd200, 24'h000000}, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, {10'h200, 8'd255, 24'h000000}, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("t4_err_count", {16'd0, err_count}, 32'd1);
    checkOutput("t4_err_last", {24'd0, err_last_code}, 32'd200);
    checkOutput("t4_no_valid", {29'd0, bd_out_v, fpga_out_v, global_out_v}, 32'd0);

    // Counter saturation
    n = 65534 - m_err;
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, {10'h200, 8'(128 + (i % 127)), 24'(i)}, 1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b1, {10'h200, 8'd150, 24'h0}, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("t5_sat", {16'd0, err_count}, 32'hFFFF);
    checkOutput("t5_last", {24'd0, err_last_code}, 32'd150);

    // Asynchronous reset while Global is full and stalled
    applyStimulus(1'b1, {10'h077, 8'd7, 24'h777777}, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #2;
    checkOutput("t6_glob_full", {31'd0, global_out_v}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("t6_async_v", {31'd0, global_out_v}, 32'd0);
    checkOutput("t6_async_err", {16'd0, err_count}, 32'd0);
    modelClear();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    applyStimulus(1'b1, {10'h033, 8'd9, 24'h999999}, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("t6_fresh_v", {31'd0, global_out_v}, 32'd1);
    checkOutput("t6_fresh", {global_out_code, global_out_payload}, 32'h09999999);

    // Randomized traffic; a refused word is held until it is taken
    pend = 1'b0;
    w = '0;
    v = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        w = randWord();
      end
      applyStimulus(v, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      pend = v && !last_accept;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
